// File: rtl/load_store_unit_sized.sv
// Memory-stage LSU: RV32 byte/half/word loads and stores over a Wishbone-classic master,
// with lane selects, load extension, misalignment traps, a bus watchdog and ALU writeback bypass.
module load_store_unit_sized #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned REG_ID_W    = 5,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_is_reg_write,
    input  logic                i_is_mem_read,
    input  logic                i_is_mem_write,
    input  logic [2:0]          i_funct3,
    input  logic [ADDR_W-1:0]   i_mem_address,
    input  logic [REG_ID_W-1:0] i_rd_id,
    input  logic [XLEN-1:0]     i_mem_data,
    input  logic [XLEN-1:0]     i_reg_data,
    output logic                o_wb_cyc,
    output logic                o_wb_stb,
    output logic                o_wb_we,
    output logic [ADDR_W-1:0]   o_wb_adr,
    output logic [XLEN/8-1:0]   o_wb_sel,
    output logic [XLEN-1:0]     o_wb_dat,
    input  logic [XLEN-1:0]     i_wb_dat,
    input  logic                i_wb_ack,
    input  logic                i_wb_err,
    output logic                o_stall,
    output logic                o_write_enable,
    output logic [REG_ID_W-1:0] o_write_address,
    output logic [XLEN-1:0]     o_write_data,
    output logic                o_fault,
    output logic [1:0]          o_fault_cause
);
    localparam int unsigned LANES = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(LANES);
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

    state_e              state_q;
    logic                cyc_q, we_q, is_load_q, wb_pend_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [LANES-1:0]    sel_q;
    logic [XLEN-1:0]     dat_q, wb_data_q;
    logic [2:0]          funct3_q;
    logic [OFF_W-1:0]    off_q;
    logic [REG_ID_W-1:0] rd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          cause_q;

    logic             mem_op, misaligned, timeout_hit;
    logic [OFF_W-1:0] off_in;
    logic [LANES-1:0] sel_in;
    logic [XLEN-1:0]  dat_in, lane_data, load_ext;

    assign mem_op      = i_is_mem_read | i_is_mem_write;
    assign off_in      = i_mem_address[OFF_W-1:0];
    assign misaligned  = (i_funct3[1:0] == 2'b01 && off_in[0]) ||
                         (i_funct3[1] && off_in[1:0] != 2'b00);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

    // Store data is replicated so the selected lanes always carry the right bytes.
    always_comb begin
        sel_in = '0;
        dat_in = '0;
        case (i_funct3[1:0])
            2'b00: begin
                sel_in = LANES'(1) << off_in;
                dat_in = {LANES{i_mem_data[7:0]}};
            end
            2'b01: begin
                sel_in = LANES'(3) << off_in;
                dat_in = {(LANES/2){i_mem_data[15:0]}};
            end
            default: begin
                sel_in = LANES'(15) << off_in;
                dat_in = {(LANES/4){i_mem_data[31:0]}};
            end
        endcase
    end

    assign lane_data = i_wb_dat >> {off_q, 3'b000};

    always_comb begin
        load_ext = '0;
        case (funct3_q[1:0])
            2'b00: begin
                if (funct3_q[2]) load_ext = XLEN'(lane_data[7:0]);
                else             load_ext = XLEN'($signed(lane_data[7:0]));
            end
            2'b01: begin
                if (funct3_q[2]) load_ext = XLEN'(lane_data[15:0]);
                else             load_ext = XLEN'($signed(lane_data[15:0]));
            end
            default: begin
                if (funct3_q[2]) load_ext = XLEN'(lane_data[31:0]);
                else             load_ext = XLEN'($signed(lane_data[31:0]));
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            is_load_q <= 1'b0;
            wb_pend_q <= 1'b0;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_q     <= '0;
            wb_data_q <= '0;
            funct3_q  <= '0;
            off_q     <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            cause_q   <= 2'b00;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mem_op && !misaligned) begin
                        state_q   <= StBus;
                        cyc_q     <= 1'b1;
                        we_q      <= !i_is_mem_read;
                        is_load_q <= i_is_mem_read;
                        adr_q     <= {i_mem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        sel_q     <= sel_in;
                        dat_q     <= dat_in;
                        funct3_q  <= i_funct3;
                        off_q     <= off_in;
                        rd_q      <= i_rd_id;
                        cnt_q     <= '0;
                        wb_pend_q <= 1'b0;
                    end else if (mem_op) begin
                        cause_q <= 2'b01;
                    end
                end
                StBus: begin
                    if (i_wb_err) begin
                        cause_q   <= 2'b10;
                        cyc_q     <= 1'b0;
                        wb_pend_q <= 1'b0;
                        state_q   <= StDone;
                    end else if (i_wb_ack) begin
                        cyc_q     <= 1'b0;
                        wb_pend_q <= is_load_q && (rd_q != '0);
                        wb_data_q <= load_ext;
                        state_q   <= StDone;
                    end else if (timeout_hit) begin
                        cause_q   <= 2'b11;
                        cyc_q     <= 1'b0;
                        wb_pend_q <= 1'b0;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    wb_pend_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign o_wb_cyc      = cyc_q;
    assign o_wb_stb      = cyc_q;
    assign o_wb_we       = we_q;
    assign o_wb_adr      = adr_q;
    assign o_wb_sel      = sel_q;
    assign o_wb_dat      = dat_q;
    assign o_fault_cause = cause_q;

    assign o_stall = !reset && ((state_q == StIdle && mem_op && !misaligned) ||
                                state_q == StBus);
    assign o_fault = !reset && ((state_q == StIdle && mem_op && misaligned) ||
                                (state_q == StBus && (i_wb_err || (!i_wb_ack && timeout_hit))));

    // ALU results bypass combinationally in IDLE; load data is only presented in DONE.
    always_comb begin
        o_write_enable  = 1'b0;
        o_write_address = rd_q;
        o_write_data    = wb_data_q;
        if (!reset) begin
            if (state_q == StIdle && !mem_op) begin
                o_write_enable  = i_is_reg_write && (i_rd_id != '0);
                o_write_address = i_rd_id;
                o_write_data    = i_reg_data;
            end else if (state_q == StDone) begin
                o_write_enable = wb_pend_q;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit_sized.sv
// Bench for load_store_unit_sized: directed spec cases plus random ops against a transaction model.
module tb_load_store_unit_sized;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_is_reg_write, i_is_mem_read, i_is_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_mem_address, i_mem_data, i_reg_data, i_wb_dat;
    logic [4:0]  i_rd_id;
    logic        i_wb_ack, i_wb_err;
    logic        o_wb_cyc, o_wb_stb, o_wb_we, o_stall, o_write_enable, o_fault;
    logic [31:0] o_wb_adr, o_wb_dat, o_write_data;
    logic [3:0]  o_wb_sel;
    logic [4:0]  o_write_address;
    logic [1:0]  o_fault_cause;

    load_store_unit_sized #(.XLEN(32), .ADDR_W(32), .REG_ID_W(5), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .i_is_reg_write(i_is_reg_write), .i_is_mem_read(i_is_mem_read),
        .i_is_mem_write(i_is_mem_write), .i_funct3(i_funct3), .i_mem_address(i_mem_address),
        .i_rd_id(i_rd_id), .i_mem_data(i_mem_data), .i_reg_data(i_reg_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr),
        .o_wb_sel(o_wb_sel), .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack),
        .i_wb_err(i_wb_err), .o_stall(o_stall), .o_write_enable(o_write_enable),
        .o_write_address(o_write_address), .o_write_data(o_write_data), .o_fault(o_fault),
        .o_fault_cause(o_fault_cause)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic        chk_en = 1'b0;
    logic        e_cyc, e_we, e_stall, e_wen, e_fault;
    logic [31:0] e_adr, e_dat, e_wdata;
    logic [3:0]  e_sel;
    logic [4:0]  e_waddr;
    logic [1:0]  e_cause, m_cause;
    logic [2:0]  load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Reference rules written as plain arithmetic on byte offsets and access sizes.
    function automatic int m_size(input logic [2:0] f3);
        return f3[1] ? 4 : (f3[0] ? 2 : 1);
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [31:0] addr);
        int v;
        v = ((1 << m_size(f3)) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_dat(input logic [2:0] f3, input logic [31:0] d);
        if (m_size(f3) == 1) return (d & 32'hFF) * 32'h01010101;
        if (m_size(f3) == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] bus);
        longint v;
        int     off;
        if (m_size(f3) == 4) return bus;
        off = int'(addr % 4);
        v = longint'((bus >> (8 * off)) & ((m_size(f3) == 2) ? 32'hFFFF : 32'hFF));
        if (!f3[2]) begin
            if (m_size(f3) == 2 && v >= 32768) v -= 65536;
            if (m_size(f3) == 1 && v >= 128) v -= 256;
        end
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc", 32'(o_wb_cyc), 32'(e_cyc));
            chk("stb", 32'(o_wb_stb), 32'(e_cyc));
            chk("stall", 32'(o_stall), 32'(e_stall));
            chk("fault", 32'(o_fault), 32'(e_fault));
            chk("cause", 32'(o_fault_cause), 32'(e_cause));
            chk("wen", 32'(o_write_enable), 32'(e_wen));
            if (e_cyc) begin
                chk("we", 32'(o_wb_we), 32'(e_we));
                chk("adr", o_wb_adr, e_adr);
                chk("sel", 32'(o_wb_sel), 32'(e_sel));
                if (e_we) chk("dat", o_wb_dat, e_dat);
            end
            if (e_wen) begin
                chk("waddr", 32'(o_write_address), 32'(e_waddr));
                chk("wdata", o_write_data, e_wdata);
            end
        end
    end

    task automatic idle_inputs();
        i_is_reg_write = 1'b0; i_is_mem_read = 1'b0; i_is_mem_write = 1'b0;
        i_funct3 = 3'd0; i_mem_address = '0; i_rd_id = '0; i_mem_data = '0;
        i_reg_data = '0; i_wb_dat = '0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        e_cyc = 1'b0; e_we = 1'b0; e_stall = 1'b0; e_wen = 1'b0; e_fault = 1'b0;
        e_adr = '0; e_dat = '0; e_wdata = '0; e_sel = '0; e_waddr = '0; e_cause = m_cause;
    endtask

    task automatic scramble();
        i_is_reg_write = 1'($urandom); i_is_mem_read = 1'($urandom);
        i_is_mem_write = 1'($urandom); i_funct3 = 3'($urandom); i_mem_address = $urandom;
        i_rd_id = 5'($urandom); i_mem_data = $urandom; i_reg_data = $urandom;
    endtask

    // resp: 0 ack after dly bus cycles, 1 err after dly, 2 no response (watchdog).
    task automatic run_op(input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] mdata,
                          input logic [31:0] rdata, input int resp, input int dly,
                          input logic [31:0] bdata, input bit lit_en,
                          input logic [31:0] lit_wdata, input logic [3:0] lit_sel);
        bit mem, mis;
        int n;
        mem = mr || mw;
        mis = mem && m_misaligned(f3, addr);
        @(posedge clk); #1;
        i_is_reg_write = rw; i_is_mem_read = mr; i_is_mem_write = mw; i_funct3 = f3;
        i_mem_address = addr; i_rd_id = rd; i_mem_data = mdata; i_reg_data = rdata;
        i_wb_ack = 1'b0; i_wb_err = 1'b0;
        e_cause = m_cause; e_cyc = 1'b0; e_fault = mis; e_stall = mem && !mis;
        e_wen = !mem && rw && rd != 0; e_waddr = rd; e_wdata = rdata;
        if (mis) m_cause = 2'b01;
        if (!mem || mis) return;
        n = (resp == 2) ? TO : dly;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            scramble();
            i_wb_ack = (i == n) && resp == 0;
            i_wb_err = (i == n) && resp == 1;
            i_wb_dat = (i == n) ? bdata : $urandom;
            e_cause = m_cause; e_cyc = 1'b1; e_stall = 1'b1; e_wen = 1'b0;
            e_we = mw && !mr; e_adr = addr & ~32'h3; e_sel = m_sel(f3, addr);
            e_dat = m_dat(f3, mdata); e_fault = (i == n) && resp != 0;
            if (lit_en) begin
                @(negedge clk);
                chk("lit_sel", 32'(o_wb_sel), 32'(lit_sel));
            end
        end
        if (resp == 1) m_cause = 2'b10;
        else if (resp == 2) m_cause = 2'b11;
        @(posedge clk); #1;
        i_wb_ack = 1'b0; i_wb_err = 1'b0;
        scramble();
        e_cause = m_cause; e_cyc = 1'b0; e_stall = 1'b0; e_fault = 1'b0;
        e_wen = mr && resp == 0 && rd != 0; e_waddr = rd; e_wdata = m_load(f3, addr, bdata);
        if (lit_en && e_wen) begin
            @(negedge clk);
            chk("lit_wdata", o_write_data, lit_wdata);
        end
    endtask

    initial begin
        int kind, resp, dly;
        logic [2:0] f3;
        logic [31:0] addr;

        reset = 1'b1;
        m_cause = 2'b00;
        idle_inputs();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_op(1, 1, 0, 3'd2, 32'h1000, 5'd1, 0, 0, 0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4'hF);
        run_op(1, 1, 0, 3'd0, 32'h1003, 5'd5, 0, 0, 0, 1, 32'h80FFFFFF, 1, 32'hFFFFFF80, 4'h8);
        run_op(1, 1, 0, 3'd4, 32'h1003, 5'd6, 0, 0, 0, 2, 32'h80FFFFFF, 1, 32'h00000080, 4'h8);
        run_op(1, 1, 0, 3'd5, 32'h1002, 5'd7, 0, 0, 0, 1, 32'h80FFFFFF, 1, 32'h000080FF, 4'hC);
        run_op(0, 0, 1, 3'd1, 32'h2002, 5'd9, 32'hCAFEBABE, 0, 0, 1, 0, 1, 0, 4'hC);
        run_op(1, 1, 0, 3'd2, 32'h1001, 5'd1, 0, 0, 0, 1, 0, 0, 0, 0);
        run_op(0, 0, 1, 3'd1, 32'h2001, 5'd0, 32'h1234, 0, 0, 1, 0, 0, 0, 0);
        run_op(1, 1, 0, 3'd2, 32'h1004, 5'd8, 0, 0, 2, 1, 32'h11111111, 0, 0, 0);
        run_op(1, 1, 0, 3'd2, 32'h1008, 5'd8, 0, 0, 1, 2, 32'h22222222, 0, 0, 0);
        run_op(1, 1, 1, 3'd0, 32'h1001, 5'd10, 32'hFF, 0, 0, 3, 32'h0000AB00, 1, 32'hFFFFFFAB,
               4'h2);
        run_op(1, 1, 0, 3'd2, 32'h1000, 5'd0, 0, 0, 0, 1, 32'h55555555, 0, 0, 0);
        run_op(1, 0, 0, 3'd0, 32'h0, 5'd2, 0, 32'h12345678, 0, 1, 0, 0, 0, 0);
        run_op(1, 0, 0, 3'd0, 32'h0, 5'd0, 0, 32'h87654321, 0, 1, 0, 0, 0, 0);

        // Reset while a bus cycle is outstanding drops cyc/stb/stall at once.
        @(posedge clk); #1;
        i_is_mem_read = 1'b1; i_funct3 = 3'd2; i_mem_address = 32'h3000; i_rd_id = 5'd3;
        e_cause = m_cause; e_stall = 1'b1; e_wen = 1'b0; e_fault = 1'b0;
        @(posedge clk); #1;
        e_cyc = 1'b1; e_we = 1'b0; e_adr = 32'h3000; e_sel = 4'hF;
        @(posedge clk); #1;
        reset = 1'b1;
        m_cause = 2'b00;
        e_cyc = 1'b0; e_stall = 1'b0; e_cause = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        run_op(1, 0, 0, 3'd0, 32'h0, 5'd2, 0, 32'h12345678, 0, 1, 0, 0, 0, 0);

        for (int k = 0; k < 200; k++) begin
            kind = $urandom_range(0, 3);
            f3 = (kind == 2) ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)];
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(m_size(f3) - 1);
            resp = $urandom_range(0, 9);
            resp = (resp < 7) ? 0 : ((resp < 9) ? 1 : 2);
            dly = $urandom_range(1, TO - 1);
            run_op(1'($urandom), kind == 1 || kind == 3, kind == 2 || kind == 3, f3, addr,
                   5'($urandom), $urandom, $urandom, resp, dly, $urandom, 0, 0, 0);
        end

        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
